wb_sel_stage: RTL and testbench

- Parametrised MEM/WB pipeline stage for the pipelined MIPS core.
- Registers the memory-stage results and control fields.
- Performs register-file destination select and write-data select, and supports sub-word load extension (lb/lbu/lh/lhu).
- Exposes a forwarding tap and a retired-instruction counter.
- Sits between the data-memory stage and the GRF write port, and feeds the hazard/forwarding unit.

---
 rtl/cpu_defs.sv | 6 +
 rtl/load_ext.sv | 23 ++
 rtl/wb_sel_stage.sv | 78 +++++++
 tb/tb_wb_sel_stage.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared encodings for the MIPS pipeline select fields
package cpu_defs;
    typedef enum logic [1:0] {A3_RT = 2'b00, A3_RD = 2'b01, A3_LINK = 2'b10, A3_NONE = 2'b11} a3_sel_e;
    typedef enum logic [1:0] {WD_ALU = 2'b00, WD_DM = 2'b01, WD_EXT = 2'b10, WD_LINK = 2'b11} wd_sel_e;
    typedef enum logic [2:0] {LD_W = 3'd0, LD_BU = 3'd1, LD_B = 3'd2, LD_HU = 3'd3, LD_H = 3'd4} ld_mode_e;
endpackage

// File: rtl/load_ext.sv
// load_ext: combinational sub-word lane select and sign/zero extension of a loaded word
module load_ext
    import cpu_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        byte_off,
    input  logic [2:0]        ld_mode,
    output logic [DATA_W-1:0] ext
);
    logic [7:0]  b;
    logic [15:0] h;
    // halfword lane ignores byte_off[0]; misalignment is trapped upstream
    always_comb begin
        b   = word[8*byte_off +: 8];
        h   = word[16*byte_off[1] +: 16];
        ext = (ld_mode == LD_BU) ? {{(DATA_W-8){1'b0}}, b} :
              (ld_mode == LD_B)  ? {{(DATA_W-8){b[7]}}, b} :
              (ld_mode == LD_HU) ? {{(DATA_W-16){1'b0}}, h} :
              (ld_mode == LD_H)  ? {{(DATA_W-16){h[15]}}, h} : word;
    end
endmodule

// File: rtl/wb_sel_stage.sv
// wb_sel_stage: MEM/WB register with GRF destination/data select, load extension and retire counter
module wb_sel_stage
    import cpu_defs::*;
#(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int LINK_REG = 31,
    parameter int LINK_OFS = 8,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  alu_res,
    input  logic [DATA_W-1:0]  dm_rdata,
    input  logic [DATA_W-1:0]  ext_imm,
    input  logic [DATA_W-1:0]  pc,
    input  logic [RADDR_W-1:0] rt,
    input  logic [RADDR_W-1:0] rd,
    input  logic [1:0]         a3_sel,
    input  logic [1:0]         wd_sel,
    input  logic [2:0]         ld_mode,
    input  logic [1:0]         byte_off,
    output logic               grf_we,
    output logic [RADDR_W-1:0] grf_a3,
    output logic [DATA_W-1:0]  grf_wd,
    output logic               fwd_valid,
    output logic               out_valid,
    output logic [CNT_W-1:0]   retired
);
    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  alu_res;
        logic [DATA_W-1:0]  dm_rdata;
        logic [DATA_W-1:0]  ext_imm;
        logic [DATA_W-1:0]  pc;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] rd;
        logic [1:0]         a3_sel;
        logic [1:0]         wd_sel;
        logic [2:0]         ld_mode;
        logic [1:0]         byte_off;
    } stage_t;
    stage_t st_q;
    logic [DATA_W-1:0] ld_wd;
    always_ff @(posedge clk) begin
        if (!reset || flush)
            st_q <= '0;
        else if (!stall)
            st_q <= '{in_valid, alu_res, dm_rdata, ext_imm, pc, rt, rd, a3_sel, wd_sel, ld_mode, byte_off};
    end
    // a flushed valid instruction still counts; reset discards it uncounted
    always_ff @(posedge clk) begin
        if (!reset)
            retired <= '0;
        else if (st_q.valid && (flush || !stall))
            retired <= retired + CNT_W'(1);
    end
    load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .word     (st_q.dm_rdata),
        .byte_off (st_q.byte_off),
        .ld_mode  (st_q.ld_mode),
        .ext      (ld_wd)
    );
    always_comb begin
        grf_a3 = (st_q.a3_sel == A3_RT)   ? st_q.rt :
                 (st_q.a3_sel == A3_RD)   ? st_q.rd :
                 (st_q.a3_sel == A3_LINK) ? RADDR_W'(LINK_REG) : '0;
        grf_wd = (st_q.wd_sel == WD_ALU) ? st_q.alu_res :
                 (st_q.wd_sel == WD_DM)  ? ld_wd :
                 (st_q.wd_sel == WD_EXT) ? st_q.ext_imm : st_q.pc + DATA_W'(LINK_OFS);
        grf_we    = st_q.valid && (grf_a3 != '0);
        fwd_valid = grf_we;
        out_valid = st_q.valid;
    end
endmodule

// File: tb/tb_wb_sel_stage.sv
// tb_wb_sel_stage: directed checks of select, load extension, stall/flush and counter wrap
module tb_wb_sel_stage;
    logic        clk = 0, reset, stall, flush, in_valid;
    logic [31:0] alu_res, dm_rdata, ext_imm, pc;
    logic [4:0]  rt, rd;
    logic [1:0]  a3_sel, wd_sel, byte_off;
    logic [2:0]  ld_mode;
    logic        grf_we, fwd_valid, out_valid;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [3:0]  retired;
    int n = 0, fails = 0;

    wb_sel_stage #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_res(alu_res), .dm_rdata(dm_rdata), .ext_imm(ext_imm), .pc(pc),
        .rt(rt), .rd(rd), .a3_sel(a3_sel), .wd_sel(wd_sel), .ld_mode(ld_mode),
        .byte_off(byte_off), .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd),
        .fwd_valid(fwd_valid), .out_valid(out_valid), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic [2:0] m, input logic [1:0] off, input logic [31:0] e, input logic [3:0] r, input string tag);
        ld_mode = m; byte_off = off;
        tick();
        chk(tag, grf_wd, e);
        chk({tag, "_ret"}, retired, r);
    endtask

    initial begin
        reset = 0; stall = 1; flush = 0; in_valid = 1;
        alu_res = 32'h1111; dm_rdata = 32'h2222; ext_imm = 32'h3333; pc = 32'h4444;
        rt = 5'd7; rd = 5'd8; a3_sel = 2'b01; wd_sel = 2'b00; ld_mode = 3'd0; byte_off = 2'd0;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_we", grf_we, 0);
        chk("rst_a3", grf_a3, 0);
        chk("rst_wd", grf_wd, 0);
        chk("rst_ret", retired, 0);

        reset = 1; stall = 0; alu_res = 32'h1234;
        tick();
        chk("alu_we", grf_we, 1);
        chk("alu_a3", grf_a3, 8);
        chk("alu_wd", grf_wd, 32'h00001234);
        chk("alu_ret", retired, 0);

        wd_sel = 2'b01; dm_rdata = 32'h80F07F81;
        ld(3'd2, 2'd0, 32'hFFFFFF81, 1, "lb0");
        ld(3'd1, 2'd0, 32'h00000081, 2, "lbu0");
        ld(3'd2, 2'd1, 32'h0000007F, 3, "lb1");
        ld(3'd4, 2'd2, 32'hFFFF80F0, 4, "lh2");
        ld(3'd3, 2'd3, 32'h000080F0, 5, "lhu3");
        ld(3'd0, 2'd1, 32'h80F07F81, 6, "lw");

        a3_sel = 2'b10; wd_sel = 2'b11; pc = 32'h00003000;
        tick();
        chk("link_a3", grf_a3, 31);
        chk("link_wd", grf_wd, 32'h00003008);
        chk("link_we", grf_we, 1);
        pc = 32'hFFFFFFFC;
        tick();
        chk("link_wrap", grf_wd, 32'h00000004);
        chk("link_ret", retired, 8);

        a3_sel = 2'b00; rt = 0; wd_sel = 2'b00; alu_res = 32'h55;
        tick();
        chk("r0_we", grf_we, 0);
        chk("r0_fwd", fwd_valid, 0);
        chk("r0_wd", grf_wd, 32'h55);
        chk("r0_valid", out_valid, 1);
        a3_sel = 2'b11; rt = 5; rd = 5;
        tick();
        chk("none_we", grf_we, 0);
        chk("none_a3", grf_a3, 0);
        chk("none_ret", retired, 10);

        a3_sel = 2'b01; rd = 3; ld_mode = 3'd2; alu_res = 32'hAAAA;
        tick();
        chk("ldm_ign", grf_wd, 32'h0000AAAA);

        rd = 9; wd_sel = 2'b10; ext_imm = 32'hDEAD0000;
        tick();
        chk("A_a3", grf_a3, 9);
        chk("A_ret", retired, 12);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rd = 5'(4 + i); ext_imm = 32'(i); wd_sel = 2'b00; alu_res = 32'hBEEF;
            tick();
        end
        chk("stall_a3", grf_a3, 9);
        chk("stall_wd", grf_wd, 32'hDEAD0000);
        chk("stall_valid", out_valid, 1);
        chk("stall_ret", retired, 12);
        flush = 1;
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_we", grf_we, 0);
        chk("flush_wd", grf_wd, 0);
        chk("flush_ret", retired, 13);

        flush = 0; stall = 0; in_valid = 0; wd_sel = 2'b01; rd = 6;
        tick();
        chk("bub_we", grf_we, 0);
        chk("bub_ret", retired, 13);
        tick();
        chk("bub2_ret", retired, 13);

        in_valid = 1;
        tick();
        chk("pre_rst_ret", retired, 13);
        reset = 0;
        tick();
        chk("mid_rst_ret", retired, 0);
        chk("mid_rst_valid", out_valid, 0);
        reset = 1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 16) chk("cnt15", retired, 15);
            if (i == 17) chk("cnt_wrap", retired, 0);
        end
        in_valid = 0;
        tick();
        chk("cnt_one", retired, 1);
        tick();
        chk("cnt_bub", retired, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
